// File: rtl/axi4_req256_master_pkg.sv
// Shared AXI4 constants, FSM state encoding and the latched-request record
// for the 256-bit single-outstanding burst master.
package axi4_req256_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam int         AXI_BEAT_BYTES  = 32;
    localparam int         LINE_LSB        = $clog2(AXI_BEAT_BYTES);
    localparam int         LINES_PER_4K    = 4096 / AXI_BEAT_BYTES;
    localparam logic [3:0] AXI_ID_DEFAULT  = 4'd0;
    localparam logic [7:0] MAX_LEN_DEFAULT = 8'd15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    typedef struct packed {
        logic [31-LINE_LSB:0] line;
        logic [7:0]           len;
    } req_t;

    // True when the last beat of the burst would land in the next 4KB page.
    function automatic logic crosses_4k(input logic [11-LINE_LSB:0] line_in_page,
                                        input logic [7:0]           len);
        logic [8:0] last_line;
        last_line = 9'(line_in_page) + {1'b0, len};
        return last_line > 9'(LINES_PER_4K - 1);
    endfunction

endpackage

// File: rtl/axi4_req256_master.sv
// Single-outstanding AXI4 256-bit burst master: request -> AW/W/B or AR/R -> one-cycle response.
// Latency: AW/AR valid 1 cycle after request; W and R data pass combinationally, so backpressure flows straight through.
module axi4_req256_master
    import axi4_req256_master_pkg::*;
#(
    parameter logic [3:0] AXI_ID  = AXI_ID_DEFAULT,
    parameter logic [7:0] MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_write_i,
    input  logic [31:0]  req_addr_i,
    input  logic [7:0]   req_len_i,
    input  logic         wr_valid_i,
    output logic         wr_ready_o,
    input  logic [255:0] wr_data_i,
    input  logic [31:0]  wr_strb_i,
    output logic         rd_valid_o,
    input  logic         rd_ready_i,
    output logic [255:0] rd_data_o,
    output logic         rd_last_o,
    output logic         resp_valid_o,
    output logic         resp_error_o,
    output logic         outport_awvalid_o,
    input  logic         outport_awready_i,
    output logic [31:0]  outport_awaddr_o,
    output logic [3:0]   outport_awid_o,
    output logic [7:0]   outport_awlen_o,
    output logic [1:0]   outport_awburst_o,
    output logic         outport_wvalid_o,
    input  logic         outport_wready_i,
    output logic [255:0] outport_wdata_o,
    output logic [31:0]  outport_wstrb_o,
    output logic         outport_wlast_o,
    input  logic         outport_bvalid_i,
    output logic         outport_bready_o,
    input  logic [1:0]   outport_bresp_i,
    input  logic [3:0]   outport_bid_i,
    output logic         outport_arvalid_o,
    input  logic         outport_arready_i,
    output logic [31:0]  outport_araddr_o,
    output logic [3:0]   outport_arid_o,
    output logic [7:0]   outport_arlen_o,
    output logic [1:0]   outport_arburst_o,
    input  logic         outport_rvalid_i,
    output logic         outport_rready_o,
    input  logic [255:0] outport_rdata_i,
    input  logic [1:0]   outport_rresp_i,
    input  logic [3:0]   outport_rid_i,
    input  logic         outport_rlast_i
);

    state_t     state_q;
    req_t       req_q;
    logic [7:0] beat_q;
    logic       err_q;

    logic        beat_last;
    logic        w_hs;
    logic        r_hs;
    logic [31:0] line_addr;

    assign beat_last = (beat_q == req_q.len);
    assign line_addr = {req_q.line, {LINE_LSB{1'b0}}};
    assign w_hs      = (state_q == ST_W) && wr_valid_i && outport_wready_i;
    assign r_hs      = (state_q == ST_R) && outport_rvalid_i && rd_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        req_q.line <= req_addr_i[31:LINE_LSB];
                        req_q.len  <= req_len_i;
                        err_q      <= 1'b0;
                        // Illegal requests complete with error and never touch the AXI port.
                        if (req_len_i > MAX_LEN || crosses_4k(req_addr_i[11:LINE_LSB], req_len_i)) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= req_write_i ? ST_AW : ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (outport_awready_i) begin
                        beat_q  <= 8'd0;
                        state_q <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        if (beat_last) state_q <= ST_B;
                        else           beat_q  <= beat_q + 8'd1;
                    end
                end
                ST_B: begin
                    if (outport_bvalid_i) begin
                        err_q   <= err_q | (outport_bresp_i != AXI_RESP_OKAY);
                        state_q <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (outport_arready_i) begin
                        beat_q  <= 8'd0;
                        state_q <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        err_q <= err_q | (outport_rresp_i != AXI_RESP_OKAY)
                                       | (outport_rlast_i != beat_last);
                        // Only the slave's rlast ends the burst; the counter saturates if rlast is late.
                        if (outport_rlast_i)      state_q <= ST_DONE;
                        else if (beat_q != 8'hFF) beat_q  <= beat_q + 8'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o       = (state_q == ST_IDLE);
    assign resp_valid_o      = (state_q == ST_DONE);
    assign resp_error_o      = (state_q == ST_DONE) && err_q;

    assign outport_awvalid_o = (state_q == ST_AW);
    assign outport_awaddr_o  = line_addr;
    assign outport_awid_o    = AXI_ID;
    assign outport_awlen_o   = req_q.len;
    assign outport_awburst_o = AXI_BURST_INCR;

    assign outport_wvalid_o  = (state_q == ST_W) && wr_valid_i;
    assign wr_ready_o        = (state_q == ST_W) && outport_wready_i;
    assign outport_wdata_o   = wr_data_i;
    assign outport_wstrb_o   = wr_strb_i;
    assign outport_wlast_o   = (state_q == ST_W) && beat_last;

    assign outport_bready_o  = (state_q == ST_B);

    assign outport_arvalid_o = (state_q == ST_AR);
    assign outport_araddr_o  = line_addr;
    assign outport_arid_o    = AXI_ID;
    assign outport_arlen_o   = req_q.len;
    assign outport_arburst_o = AXI_BURST_INCR;

    assign rd_valid_o        = (state_q == ST_R) && outport_rvalid_i;
    assign outport_rready_o  = (state_q == ST_R) && rd_ready_i;
    assign rd_data_o         = outport_rdata_i;
    assign rd_last_o         = (state_q == ST_R) && outport_rlast_i;

    logic unused_ok;
    assign unused_ok = ^{outport_bid_i, outport_rid_i, req_addr_i[LINE_LSB-1:0]};

endmodule

// File: tb/tb_axi4_req256_master.sv
// Directed bench for axi4_req256_master: a hand-driven AXI slave and requester,
// one task per scenario with inline expected-value comparisons.
module tb_axi4_req256_master;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i, req_ready_o, req_write_i;
    logic [31:0]  req_addr_i;
    logic [7:0]   req_len_i;
    logic         wr_valid_i, wr_ready_o;
    logic [255:0] wr_data_i;
    logic [31:0]  wr_strb_i;
    logic         rd_valid_o, rd_ready_i, rd_last_o;
    logic [255:0] rd_data_o;
    logic         resp_valid_o, resp_error_o;
    logic         outport_awvalid_o, outport_awready_i;
    logic [31:0]  outport_awaddr_o;
    logic [3:0]   outport_awid_o;
    logic [7:0]   outport_awlen_o;
    logic [1:0]   outport_awburst_o;
    logic         outport_wvalid_o, outport_wready_i, outport_wlast_o;
    logic [255:0] outport_wdata_o;
    logic [31:0]  outport_wstrb_o;
    logic         outport_bvalid_i, outport_bready_o;
    logic [1:0]   outport_bresp_i;
    logic [3:0]   outport_bid_i;
    logic         outport_arvalid_o, outport_arready_i;
    logic [31:0]  outport_araddr_o;
    logic [3:0]   outport_arid_o;
    logic [7:0]   outport_arlen_o;
    logic [1:0]   outport_arburst_o;
    logic         outport_rvalid_i, outport_rready_o;
    logic [255:0] outport_rdata_i;
    logic [1:0]   outport_rresp_i;
    logic [3:0]   outport_rid_i;
    logic         outport_rlast_i;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [255:0] got_data [16];
    logic         got_last [16];
    int           n_acc;
    logic         stall_rready;
    logic         early_resp;

    always #5 clk_i = ~clk_i;

    axi4_req256_master dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .resp_valid_o(resp_valid_o), .resp_error_o(resp_error_o),
        .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
        .outport_awaddr_o(outport_awaddr_o), .outport_awid_o(outport_awid_o),
        .outport_awlen_o(outport_awlen_o), .outport_awburst_o(outport_awburst_o),
        .outport_wvalid_o(outport_wvalid_o), .outport_wready_i(outport_wready_i),
        .outport_wdata_o(outport_wdata_o), .outport_wstrb_o(outport_wstrb_o), .outport_wlast_o(outport_wlast_o),
        .outport_bvalid_i(outport_bvalid_i), .outport_bready_o(outport_bready_o),
        .outport_bresp_i(outport_bresp_i), .outport_bid_i(outport_bid_i),
        .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
        .outport_araddr_o(outport_araddr_o), .outport_arid_o(outport_arid_o),
        .outport_arlen_o(outport_arlen_o), .outport_arburst_o(outport_arburst_o),
        .outport_rvalid_i(outport_rvalid_i), .outport_rready_o(outport_rready_o),
        .outport_rdata_i(outport_rdata_i), .outport_rresp_i(outport_rresp_i),
        .outport_rid_i(outport_rid_i), .outport_rlast_i(outport_rlast_i)
    );

    function automatic logic [255:0] rd_pat(input int i);
        return {8{32'(32'hD000_0000 + i)}};
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the handshake edge.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [7:0] l);
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_len_i = l;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic ar_accept();
        outport_arready_i = 1'b1;
        @(negedge clk_i);
        outport_arready_i = 1'b0;
    endtask

    task automatic serve_read(input int nb, input logic [15:0] lmask, input int stall_idx, input int stall_cyc);
        n_acc = 0; stall_rready = 1'b0; early_resp = 1'b0;
        for (int i = 0; i < nb; i++) begin
            outport_rvalid_i = 1'b1; outport_rdata_i = rd_pat(i);
            outport_rlast_i = lmask[i]; outport_rresp_i = 2'b00;
            if (i == stall_idx) begin
                rd_ready_i = 1'b0;
                for (int s = 0; s < stall_cyc; s++) begin
                    #1; stall_rready |= outport_rready_o;
                    @(negedge clk_i);
                end
                rd_ready_i = 1'b1;
            end
            #1;
            if (rd_valid_o && outport_rready_o) begin
                got_data[n_acc] = rd_data_o; got_last[n_acc] = rd_last_o; n_acc++;
            end
            early_resp |= resp_valid_o;
            @(negedge clk_i);
        end
        outport_rvalid_i = 1'b0; outport_rlast_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; wr_valid_i = 1'b1; outport_rvalid_i = 1'b1; rd_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
        n_cmp++; if ({outport_awvalid_o, outport_arvalid_o, outport_wvalid_o, outport_bready_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_axi_valids: got %b want 0000", {outport_awvalid_o, outport_arvalid_o, outport_wvalid_o, outport_bready_o}); end
        n_cmp++; if ({outport_rready_o, rd_valid_o, wr_ready_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_data_handshake: got %b want 000", {outport_rready_o, rd_valid_o, wr_ready_o}); end
        n_cmp++; if ({resp_valid_o, resp_error_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_resp: got %b want 00", {resp_valid_o, resp_error_o}); end
        n_cmp++; if ({outport_awaddr_o, outport_awlen_o} !== 40'd0) begin
            n_fail++; $display("FAIL reset_stored_addr_len: got %h want 0", {outport_awaddr_o, outport_awlen_o}); end
        rst_i = 1'b0; wr_valid_i = 1'b0; outport_rvalid_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_read_basic();
        logic [3:0] lm;
        do_req(1'b0, 32'h0000_1040, 8'd3);
        n_cmp++; if (outport_arvalid_o !== 1'b1 || outport_awvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_arvalid_latency: got ar=%b aw=%b want ar=1 aw=0", outport_arvalid_o, outport_awvalid_o); end
        n_cmp++; if ({outport_araddr_o, outport_arlen_o, outport_arburst_o, outport_arid_o} !== {32'h0000_1040, 8'd3, 2'b01, 4'd0}) begin
            n_fail++; $display("FAIL rd_ar_fields: got addr=%h len=%0d burst=%b id=%0d want 1040/3/01/0",
                outport_araddr_o, outport_arlen_o, outport_arburst_o, outport_arid_o); end
        n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rd_busy_req_ready: got %b want 0", req_ready_o); end
        ar_accept();
        serve_read(4, 16'h0008, -1, 0);
        n_cmp++; if (n_acc !== 4) begin n_fail++; $display("FAIL rd_beat_count: got %0d want 4", n_acc); end
        lm = '0;
        for (int i = 0; i < 4; i++) begin
            lm[i] = got_last[i];
            n_cmp++; if (got_data[i] !== rd_pat(i)) begin n_fail++; $display("FAIL rd_data_beat%0d: got %h want %h", i, got_data[i][31:0], 32'(32'hD000_0000 + i)); end
        end
        n_cmp++; if (lm !== 4'b1000) begin n_fail++; $display("FAIL rd_last_pattern: got %b want 1000", lm); end
        n_cmp++; if ({early_resp, resp_valid_o, resp_error_o} !== 3'b010) begin
            n_fail++; $display("FAIL rd_resp: got early/valid/err=%b want 010", {early_resp, resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
        n_cmp++; if ({resp_valid_o, req_ready_o} !== 2'b01) begin
            n_fail++; $display("FAIL rd_resp_one_cycle: got valid/ready=%b want 01", {resp_valid_o, req_ready_o}); end
    endtask

    task automatic test_write();
        int nb, cyc;
        logic [1:0] wl;
        logic pass_ok;
        for (int t = 0; t < 2; t++) begin
            wr_valid_i = 1'b1; wr_data_i = '1; wr_strb_i = '1;
            do_req(1'b1, 32'h0000_201F, 8'd1);
            #1;
            n_cmp++; if ({outport_awvalid_o, outport_wvalid_o, wr_ready_o} !== 3'b100) begin
                n_fail++; $display("FAIL wr_aw_before_w_%0d: got aw/w/wrdy=%b want 100", t, {outport_awvalid_o, outport_wvalid_o, wr_ready_o}); end
            n_cmp++; if ({outport_awaddr_o, outport_awlen_o, outport_awburst_o, outport_awid_o} !== {32'h0000_2000, 8'd1, 2'b01, 4'd0}) begin
                n_fail++; $display("FAIL wr_aw_fields_%0d: got addr=%h len=%0d burst=%b id=%0d want 2000/1/01/0",
                    t, outport_awaddr_o, outport_awlen_o, outport_awburst_o, outport_awid_o); end
            outport_awready_i = 1'b1;
            @(negedge clk_i);
            outport_awready_i = 1'b0;
            nb = 0; cyc = 0; wl = 2'b00; pass_ok = 1'b1;
            while (nb < 2 && cyc < 10) begin
                outport_wready_i = (cyc % 2 == 0);
                wr_data_i = {8{32'(32'hA000_0000 + nb)}};
                wr_strb_i = 32'(nb + 1);
                #1;
                pass_ok &= (wr_ready_o === outport_wready_i) && (outport_wvalid_o === 1'b1);
                if (outport_wvalid_o && wr_ready_o) begin
                    pass_ok &= (outport_wdata_o === {8{32'(32'hA000_0000 + nb)}}) && (outport_wstrb_o === 32'(nb + 1));
                    wl[nb] = outport_wlast_o;
                    nb++;
                end
                cyc++;
                @(negedge clk_i);
            end
            wr_valid_i = 1'b0; outport_wready_i = 1'b0;
            n_cmp++; if (nb !== 2 || cyc !== 3) begin n_fail++; $display("FAIL wr_beats_%0d: got %0d beats in %0d cycles want 2 in 3", t, nb, cyc); end
            n_cmp++; if (wl !== 2'b10) begin n_fail++; $display("FAIL wr_wlast_%0d: got %b want 10", t, wl); end
            n_cmp++; if (pass_ok !== 1'b1) begin n_fail++; $display("FAIL wr_passthrough_%0d: got %b want 1", t, pass_ok); end
            n_cmp++; if (outport_bready_o !== 1'b1) begin n_fail++; $display("FAIL wr_bready_%0d: got %b want 1", t, outport_bready_o); end
            outport_bvalid_i = 1'b1; outport_bresp_i = (t == 0) ? 2'b00 : 2'b10;
            @(negedge clk_i);
            outport_bvalid_i = 1'b0; outport_bresp_i = 2'b00;
            n_cmp++; if ({resp_valid_o, resp_error_o} !== {1'b1, t[0]}) begin
                n_fail++; $display("FAIL wr_resp_%0d: got valid/err=%b want 1%0d", t, {resp_valid_o, resp_error_o}, t); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reject();
        do_req(1'b1, 32'h0000_0FE0, 8'd1);
        n_cmp++; if ({outport_awvalid_o, outport_arvalid_o, resp_valid_o, resp_error_o} !== 4'b0011) begin
            n_fail++; $display("FAIL rej_4k_cross: got aw/ar/valid/err=%b want 0011", {outport_awvalid_o, outport_arvalid_o, resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
        n_cmp++; if ({resp_valid_o, resp_error_o, req_ready_o} !== 3'b001) begin
            n_fail++; $display("FAIL rej_back_idle: got valid/err/ready=%b want 001", {resp_valid_o, resp_error_o, req_ready_o}); end
        do_req(1'b0, 32'h0000_0000, 8'd16);
        n_cmp++; if ({outport_awvalid_o, outport_arvalid_o, resp_valid_o, resp_error_o} !== 4'b0011) begin
            n_fail++; $display("FAIL rej_len16: got aw/ar/valid/err=%b want 0011", {outport_awvalid_o, outport_arvalid_o, resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
        // Last line of a page with a single beat is legal.
        do_req(1'b0, 32'h0000_0FE0, 8'd0);
        n_cmp++; if ({outport_arvalid_o, outport_araddr_o, resp_valid_o} !== {1'b1, 32'h0000_0FE0, 1'b0}) begin
            n_fail++; $display("FAIL edge_page_accept: got ar=%b addr=%h valid=%b want 1/0fe0/0", outport_arvalid_o, outport_araddr_o, resp_valid_o); end
        ar_accept();
        serve_read(1, 16'h0001, -1, 0);
        n_cmp++; if ({n_acc == 1, resp_valid_o, resp_error_o} !== 3'b110) begin
            n_fail++; $display("FAIL edge_page_resp: got acc=%0d valid/err=%b want 1/10", n_acc, {resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
    endtask

    task automatic test_rlast_mismatch();
        do_req(1'b0, 32'h0000_0400, 8'd2);
        ar_accept();
        serve_read(2, 16'b0010, -1, 0);
        n_cmp++; if ({n_acc == 2, resp_valid_o, resp_error_o} !== 3'b111) begin
            n_fail++; $display("FAIL rlast_early: got acc=%0d valid/err=%b want 2/11", n_acc, {resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
        do_req(1'b0, 32'h0000_0400, 8'd2);
        ar_accept();
        serve_read(4, 16'b1000, -1, 0);
        n_cmp++; if (n_acc !== 4 || early_resp !== 1'b0) begin
            n_fail++; $display("FAIL rlast_late_beats: got acc=%0d early=%b want 4/0", n_acc, early_resp); end
        n_cmp++; if ({resp_valid_o, resp_error_o} !== 2'b11) begin
            n_fail++; $display("FAIL rlast_late_resp: got valid/err=%b want 11", {resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
    endtask

    task automatic test_rd_stall();
        do_req(1'b0, 32'h0000_3000, 8'd3);
        ar_accept();
        serve_read(4, 16'h0008, 1, 5);
        n_cmp++; if (stall_rready !== 1'b0) begin n_fail++; $display("FAIL stall_rready: got %b want 0", stall_rready); end
        n_cmp++; if (n_acc !== 4) begin n_fail++; $display("FAIL stall_beat_count: got %0d want 4", n_acc); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got_data[i] !== rd_pat(i)) begin n_fail++; $display("FAIL stall_order_beat%0d: got %h want %h", i, got_data[i][31:0], 32'(32'hD000_0000 + i)); end
        end
        n_cmp++; if ({resp_valid_o, resp_error_o} !== 2'b10) begin
            n_fail++; $display("FAIL stall_resp: got valid/err=%b want 10", {resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
    endtask

    task automatic test_reset_midburst();
        wr_valid_i = 1'b1; wr_data_i = '0; wr_strb_i = '1;
        do_req(1'b1, 32'h0000_5000, 8'd3);
        outport_awready_i = 1'b1;
        @(negedge clk_i);
        outport_awready_i = 1'b0; outport_wready_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        n_cmp++; if ({outport_awvalid_o, outport_wvalid_o, wr_ready_o, outport_bready_o, outport_arvalid_o, outport_rready_o} !== 6'b000000) begin
            n_fail++; $display("FAIL midrst_valids: got %b want 000000",
                {outport_awvalid_o, outport_wvalid_o, wr_ready_o, outport_bready_o, outport_arvalid_o, outport_rready_o}); end
        n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready: got %b want 1", req_ready_o); end
        rst_i = 1'b0; wr_valid_i = 1'b0; outport_wready_i = 1'b0;
        @(negedge clk_i);
        do_req(1'b0, 32'h0000_6000, 8'd0);
        n_cmp++; if ({outport_arvalid_o, outport_araddr_o, outport_arlen_o} !== {1'b1, 32'h0000_6000, 8'd0}) begin
            n_fail++; $display("FAIL midrst_new_ar: got ar=%b addr=%h len=%0d want 1/6000/0", outport_arvalid_o, outport_araddr_o, outport_arlen_o); end
        ar_accept();
        serve_read(1, 16'h0001, -1, 0);
        n_cmp++; if ({n_acc == 1, resp_valid_o, resp_error_o} !== 3'b110) begin
            n_fail++; $display("FAIL midrst_new_resp: got acc=%0d valid/err=%b want 1/10", n_acc, {resp_valid_o, resp_error_o}); end
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_len_i = '0;
        wr_valid_i = 1'b0; wr_data_i = '0; wr_strb_i = '0; rd_ready_i = 1'b1;
        outport_awready_i = 1'b0; outport_wready_i = 1'b0;
        outport_bvalid_i = 1'b0; outport_bresp_i = 2'b00; outport_bid_i = 4'd0;
        outport_arready_i = 1'b0; outport_rvalid_i = 1'b0; outport_rdata_i = '0;
        outport_rresp_i = 2'b00; outport_rid_i = 4'd0; outport_rlast_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_read_basic();
        test_write();
        test_reject();
        test_rlast_mismatch();
        test_rd_stall();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
